// File: rtl/swap_pkg.sv
// Shared definitions for the sequential XOR swap engine: FSM state codes and
// default operand/counter widths.
package swap_pkg;

    typedef logic [1:0] state_t;

    localparam state_t S_IDLE = 2'd0;
    localparam state_t S_X1   = 2'd1;
    localparam state_t S_X2   = 2'd2;
    localparam state_t S_X3   = 2'd3;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_CNT_W = 16;

endpackage

// File: rtl/xor_swap_seq.sv
// Multi-cycle register swap using a^=b, b^=a, a^=b on two working registers,
// with a start/busy/done handshake and a wrapping completed-swap counter.
module xor_swap_seq
    import swap_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] a_out,
    output logic [WIDTH-1:0] b_out,
    output logic [CNT_W-1:0] swap_count
);

    localparam logic [CNT_W-1:0] CNT_ONE = 1;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] ra, rb, x;
    logic             ld_in, ld_a, ld_b, fin;

    // The single shared XOR feeds every step.
    assign x = ra ^ rb;

    always_ff @(posedge clk) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start) state_nxt = S_X1;
            S_X1:    state_nxt = S_X2;
            S_X2:    state_nxt = S_X3;
            S_X3:    state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        busy  = (state != S_IDLE);
        ld_in = (state == S_IDLE) && start;
        ld_a  = (state == S_X1) || (state == S_X3);
        ld_b  = (state == S_X2);
        fin   = (state == S_X3);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ra         <= '0;
            rb         <= '0;
            a_out      <= '0;
            b_out      <= '0;
            done       <= 1'b0;
            swap_count <= '0;
        end else begin
            done <= 1'b0;
            if (ld_in) begin
                ra <= a_in;
                rb <= b_in;
            end
            if (ld_a) ra <= x;
            if (ld_b) rb <= x;
            // Outputs take the finished pair directly so intermediates never leak.
            if (fin) begin
                a_out      <= x;
                b_out      <= rb;
                done       <= 1'b1;
                swap_count <= swap_count + CNT_ONE;
            end
        end
    end

endmodule
